// File: rtl/ring_idx_pkg.sv
// ring_idx_pkg: shared arithmetic for flipped-bit ring indices {flipped, idx}.
// Indices travel through these helpers zero-extended into a 32-bit word, with
// the flipped bit at position $clog2(size) and idx in the bits below it.
// Consumers (ROB, LQ, SQ, immBuffer) use these instead of ad-hoc pointer math.
//   ring_idx_add  (idx, n, size) : idx advanced by n, wrapping at size-1 -> 0
//   ring_idx_dist (a, b, size)   : number of entries from a up to (not incl.) b
//   ring_idx_older(a, b, size)   : a allocated before b
package ring_idx_pkg;

    typedef logic [31:0] ring_word_t;

    // Width of the idx field for a given depth; evaluates to a constant when
    // size is a parameter, so the loop folds away in synthesis.
    function automatic int unsigned ring_iw(input int unsigned size);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < size) w = i + 1;
        end
        return w;
    endfunction

    function automatic ring_word_t ring_idx_add(input ring_word_t idx,
                                                input int unsigned n,
                                                input int unsigned size);
        int unsigned iw;
        int unsigned sum;
        logic        flip;
        ring_word_t  res;
        iw   = ring_iw(size);
        flip = idx[iw];
        sum  = (idx & ((32'd1 << iw) - 32'd1)) + n;
        // n never exceeds size, so a single subtraction covers the wrap
        if (sum >= size) begin
            sum  = sum - size;
            flip = ~flip;
        end
        res     = sum;
        res[iw] = flip;
        return res;
    endfunction

    function automatic int unsigned ring_idx_dist(input ring_word_t a,
                                                  input ring_word_t b,
                                                  input int unsigned size);
        int unsigned iw;
        int unsigned ai;
        int unsigned bi;
        iw = ring_iw(size);
        ai = a & ((32'd1 << iw) - 32'd1);
        bi = b & ((32'd1 << iw) - 32'd1);
        if (a[iw] == b[iw]) return bi - ai;
        return size - ai + bi;
    endfunction

    function automatic logic ring_idx_older(input ring_word_t a,
                                            input ring_word_t b,
                                            input int unsigned size);
        int unsigned iw;
        int unsigned ai;
        int unsigned bi;
        iw = ring_iw(size);
        ai = a & ((32'd1 << iw) - 32'd1);
        bi = b & ((32'd1 << iw) - 32'd1);
        if (a[iw] == b[iw]) return ai < bi;
        return ai > bi;
    endfunction

endpackage

// File: rtl/ring_idx_adder.sv
// ring_idx_adder: combinational wrap adder for one flipped-bit ring index.
//   a : base index {flipped, idx}
//   n : increment, 0..MAXN
//   y : a + n, idx wrapping at SIZE-1 -> 0 with flipped toggled
module ring_idx_adder
    import ring_idx_pkg::*;
#(
    parameter  int unsigned SIZE = 128,
    parameter  int unsigned MAXN = 4,
    localparam int unsigned IW   = $clog2(SIZE),
    localparam int unsigned NW   = $clog2(MAXN + 1)
) (
    input  logic [IW:0]   a,
    input  logic [NW-1:0] n,
    output logic [IW:0]   y
);

    always_comb begin
        y = (IW + 1)'(ring_idx_add(32'(a), 32'(n), SIZE));
    end

endmodule

// File: rtl/ring_idx_alloc.sv
// ring_idx_alloc: allocator for flipped-bit ring indices.
// Hands out up to ALLOC_WIDTH consecutive indices per cycle from the tail,
// retires up to DEALLOC_WIDTH per cycle from the head and rolls the tail back
// on squash. Every output comes from the head/tail/count registers only.
//   clk, rst        : clock, synchronous active-high reset
//   i_alloc_req     : contiguous-from-bit-0 request mask (all-or-nothing)
//   o_can_alloc     : at least ALLOC_WIDTH free entries
//   o_alloc_idx     : slot k = tail + k
//   i_dealloc_num   : entries retired from head this cycle
//   i_squash_vld/idx: rewind tail to i_squash_idx (wins over allocation)
//   o_head, o_tail  : oldest live index / next index to allocate
//   o_count, o_free : live / free entries
//   o_empty, o_full : count == 0 / count == SIZE
module ring_idx_alloc
    import ring_idx_pkg::*;
#(
    parameter int unsigned SIZE          = 128,
    parameter int unsigned ALLOC_WIDTH   = 4,
    parameter int unsigned DEALLOC_WIDTH = 4,
    parameter int unsigned IW            = $clog2(SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ALLOC_WIDTH-1:0]               i_alloc_req,
    output logic                                 o_can_alloc,
    output logic [ALLOC_WIDTH*(IW+1)-1:0]        o_alloc_idx,
    input  logic [$clog2(DEALLOC_WIDTH+1)-1:0]   i_dealloc_num,
    input  logic                                 i_squash_vld,
    input  logic [IW:0]                          i_squash_idx,
    output logic [IW:0]                          o_head,
    output logic [IW:0]                          o_tail,
    output logic [$clog2(SIZE+1)-1:0]            o_count,
    output logic [$clog2(SIZE+1)-1:0]            o_free,
    output logic                                 o_empty,
    output logic                                 o_full
);

    localparam int unsigned CW = $clog2(SIZE + 1);
    localparam int unsigned AW = $clog2(ALLOC_WIDTH + 1);

    logic [IW:0]   head_q, tail_q;
    logic [IW:0]   head_inc, tail_inc;
    logic [IW:0]   head_d, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] nalloc;
    logic          alloc_fire;

    always_comb begin
        nalloc = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            nalloc = nalloc + AW'(i_alloc_req[i]);
        end
    end

    assign o_head      = head_q;
    assign o_tail      = tail_q;
    assign o_count     = count_q;
    assign o_free      = CW'(SIZE) - count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == CW'(SIZE));
    assign o_can_alloc = (o_free >= CW'(ALLOC_WIDTH));
    assign alloc_fire  = (|i_alloc_req) && o_can_alloc;

    for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_slot
        ring_idx_adder #(.SIZE(SIZE), .MAXN(ALLOC_WIDTH)) u_slot_add (
            .a (tail_q),
            .n (AW'(k)),
            .y (o_alloc_idx[k*(IW+1) +: IW+1])
        );
    end

    ring_idx_adder #(.SIZE(SIZE), .MAXN(ALLOC_WIDTH)) u_tail_add (
        .a (tail_q),
        .n (nalloc),
        .y (tail_inc)
    );

    ring_idx_adder #(.SIZE(SIZE), .MAXN(DEALLOC_WIDTH)) u_head_add (
        .a (head_q),
        .n (i_dealloc_num),
        .y (head_inc)
    );

    // Squash takes priority over allocation, but retirement still advances
    // head, so the post-squash count is measured from the advanced head.
    always_comb begin
        head_d  = head_inc;
        tail_d  = tail_q;
        count_d = CW'({1'b0, count_q} - (CW + 1)'(i_dealloc_num));
        if (i_squash_vld) begin
            tail_d  = i_squash_idx;
            count_d = CW'(ring_idx_dist(32'(head_inc), 32'(i_squash_idx), SIZE));
        end else if (alloc_fire) begin
            tail_d  = tail_inc;
            count_d = CW'({1'b0, count_q} + (CW + 1)'(nalloc)
                          - (CW + 1)'(i_dealloc_num));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    a_dealloc_le_count : assert property (@(posedge clk) disable iff (rst)
        32'(i_dealloc_num) <= 32'(count_q));

    a_squash_in_range : assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |->
            (!ring_idx_older(32'(i_squash_idx), 32'(head_inc), SIZE) &&
             !ring_idx_older(32'(tail_q), 32'(i_squash_idx), SIZE)));

endmodule

// File: tb/tb_ring_idx_alloc.sv
// Bench for ring_idx_alloc at SIZE=60 and SIZE=128. The reference model tracks
// head and tail as unbounded absolute positions; ring indices are derived as
// {(pos/SIZE)%2, pos%SIZE} and count as tail-head.
module tb_ring_idx_alloc;

    localparam int unsigned S0  = 60;
    localparam int unsigned S1  = 128;
    localparam int unsigned IW0 = $clog2(S0);
    localparam int unsigned IW1 = $clog2(S1);
    localparam int unsigned CW0 = $clog2(S0 + 1);
    localparam int unsigned CW1 = $clog2(S1 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]         req0, req1;
    logic               can0, can1;
    logic [4*(IW0+1)-1:0] aidx0;
    logic [4*(IW1+1)-1:0] aidx1;
    logic [2:0]         dn0, dn1;
    logic               sqv0, sqv1;
    logic [IW0:0]       sqi0, head0, tail0;
    logic [IW1:0]       sqi1, head1, tail1;
    logic [CW0-1:0]     cnt0, free0;
    logic [CW1-1:0]     cnt1, free1;
    logic               emp0, full0, emp1, full1;

    ring_idx_alloc #(.SIZE(S0), .ALLOC_WIDTH(4), .DEALLOC_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .i_alloc_req(req0), .o_can_alloc(can0),
        .o_alloc_idx(aidx0), .i_dealloc_num(dn0), .i_squash_vld(sqv0),
        .i_squash_idx(sqi0), .o_head(head0), .o_tail(tail0), .o_count(cnt0),
        .o_free(free0), .o_empty(emp0), .o_full(full0)
    );

    ring_idx_alloc #(.SIZE(S1), .ALLOC_WIDTH(4), .DEALLOC_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .i_alloc_req(req1), .o_can_alloc(can1),
        .o_alloc_idx(aidx1), .i_dealloc_num(dn1), .i_squash_vld(sqv1),
        .i_squash_idx(sqi1), .o_head(head1), .o_tail(tail1), .o_count(cnt1),
        .o_free(free1), .o_empty(emp1), .o_full(full1)
    );

    int     checks = 0;
    int     errors = 0;
    longint mh[2];
    longint mt[2];
    longint sz[2]  = '{60, 128};
    int     iwv[2] = '{IW0, IW1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint enc(input int w, input longint pos);
        return (((pos / sz[w]) % 2) << iwv[w]) | (pos % sz[w]);
    endfunction

    task automatic idle();
        req0 = '0; dn0 = '0; sqv0 = 1'b0; sqi0 = '0;
        req1 = '0; dn1 = '0; sqv1 = 1'b0; sqi1 = '0;
    endtask

    task automatic check_state(input int w, input string ph);
        longint      c;
        logic [63:0] h, t, cn, fr, em, fu, ca;
        logic [63:0] sl [4];
        c = mt[w] - mh[w];
        if (w == 0) begin
            h = 64'(head0); t = 64'(tail0); cn = 64'(cnt0); fr = 64'(free0);
            em = 64'(emp0); fu = 64'(full0); ca = 64'(can0);
            for (int k = 0; k < 4; k++) sl[k] = 64'(aidx0[k*(IW0+1) +: IW0+1]);
        end else begin
            h = 64'(head1); t = 64'(tail1); cn = 64'(cnt1); fr = 64'(free1);
            em = 64'(emp1); fu = 64'(full1); ca = 64'(can1);
            for (int k = 0; k < 4; k++) sl[k] = 64'(aidx1[k*(IW1+1) +: IW1+1]);
        end
        chk($sformatf("%s/%0d head", ph, w), h, 64'(enc(w, mh[w])));
        chk($sformatf("%s/%0d tail", ph, w), t, 64'(enc(w, mt[w])));
        chk($sformatf("%s/%0d count", ph, w), cn, 64'(c));
        chk($sformatf("%s/%0d free", ph, w), fr, 64'(sz[w] - c));
        chk($sformatf("%s/%0d empty", ph, w), em, 64'(c == 0));
        chk($sformatf("%s/%0d full", ph, w), fu, 64'(c == sz[w]));
        chk($sformatf("%s/%0d can_alloc", ph, w), ca, 64'((sz[w] - c) >= 4));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s/%0d slot%0d", ph, w, k), sl[k], 64'(enc(w, mt[w] + k)));
    endtask

    // Drive one cycle on instance w and advance the model by the same rules.
    task automatic cycle(input int w, input int n, input int nd, input bit sq,
                         input longint sqpos);
        logic [3:0] m;
        longint     c;
        bit         ca;
        m  = 4'((1 << n) - 1);
        c  = mt[w] - mh[w];
        ca = (sz[w] - c) >= 4;
        if (w == 0) begin
            req0 = m; dn0 = 3'(nd); sqv0 = sq; sqi0 = (IW0 + 1)'(enc(0, sqpos));
        end else begin
            req1 = m; dn1 = 3'(nd); sqv1 = sq; sqi1 = (IW1 + 1)'(enc(1, sqpos));
        end
        mh[w] += nd;
        if (sq) mt[w] = sqpos;
        else if (n > 0 && ca) mt[w] += n;
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mh = '{0, 0};
        mt = '{0, 0};
    endtask

    task automatic run_random(input int w, input int ncyc);
        longint c, lo;
        int     n, nd;
        bit     sq;
        longint sp;
        for (int i = 0; i < ncyc; i++) begin
            c  = mt[w] - mh[w];
            n  = $urandom_range(0, 4);
            nd = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (c < 4) ? int'(c) : 4) : 0;
            sq = ($urandom_range(0, 9) == 0);
            lo = mh[w] + nd;
            sp = lo + $urandom_range(0, int'(mt[w] - lo));
            cycle(w, n, nd, sq, sp);
            check_state(w, "rand");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        do_reset();
        check_state(0, "reset");
        check_state(1, "reset");
        chk("reset_free", 64'(free0), 64'd60);
        chk("reset_slot3", 64'(aidx0[3*(IW0+1) +: IW0+1]), 64'd3);

        // Fill to 56, then one more group of 4 makes the ring full.
        for (int i = 0; i < 14; i++) cycle(0, 4, 0, 0, 0);
        check_state(0, "fill56");
        chk("fill56_slot1", 64'(aidx0[1*(IW0+1) +: IW0+1]), 64'd57);
        cycle(0, 4, 0, 0, 0);
        check_state(0, "full");
        chk("full_flag", 64'(full0), 64'd1);
        chk("full_tail", 64'(tail0), 64'd64);
        chk("full_head", 64'(head0), 64'd0);
        cycle(0, 4, 0, 0, 0);
        chk("full_hold_tail", 64'(tail0), 64'd64);

        // Fill to 56, then a partial 4'b0011 request.
        do_reset();
        for (int i = 0; i < 14; i++) cycle(0, 4, 0, 0, 0);
        cycle(0, 2, 0, 0, 0);
        check_state(0, "wrap");
        chk("wrap_tail", 64'(tail0), 64'd58);
        chk("wrap_can", 64'(can0), 64'd0);

        // Simultaneous alloc 3 + dealloc 4 at count 10.
        do_reset();
        cycle(0, 4, 0, 0, 0); cycle(0, 4, 0, 0, 0); cycle(0, 2, 0, 0, 0);
        cycle(0, 3, 4, 0, 0);
        check_state(0, "simul");
        chk("simul_count", 64'(cnt0), 64'd9);
        chk("simul_tail", 64'(tail0), 64'd13);

        // Squash with concurrent alloc and dealloc.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 4, 0, 0, 0);
        cycle(0, 0, 4, 0, 0); cycle(0, 0, 1, 0, 0);
        cycle(0, 4, 2, 1, 12);
        check_state(0, "squash");
        chk("squash_tail", 64'(tail0), 64'd12);
        chk("squash_head", 64'(head0), 64'd7);
        chk("squash_count", 64'(cnt0), 64'd5);

        // Walk head to {1,3}, then reset with junk inputs present.
        do_reset();
        for (int i = 0; i < 100 && mh[0] != 63; i++) begin
            longint c, r;
            int nd;
            c  = mt[0] - mh[0];
            r  = 63 - mh[0];
            nd = int'((c < r) ? c : r);
            if (nd > 4) nd = 4;
            cycle(0, 4, nd, 0, 0);
        end
        chk("midop_head", 64'(head0), 64'd67);
        req0 = 4'b1111; dn0 = 3'd3; sqv0 = 1'b1; sqi0 = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        mh = '{0, 0};
        mt = '{0, 0};
        check_state(0, "midrst");

        // SIZE=128: tail {0,127} + 1 -> {1,0}.
        cycle(1, 4, 0, 0, 0);
        for (int i = 0; i < 30; i++) cycle(1, 4, 4, 0, 0);
        cycle(1, 3, 4, 0, 0);
        chk("s128_tail127", 64'(tail1), 64'd127);
        cycle(1, 1, 0, 0, 0);
        check_state(1, "s128wrap");
        chk("s128_tail_wrap", 64'(tail1), 64'd128);

        run_random(0, 1500);
        run_random(1, 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
